inst_fetch_axi: RTL
===================

// Module: inst_fetch_axi
// PURPOSE
//  Dual-issue instruction fetch master; feeds the IF_1/IF_2 stage pair.
//  Sequences the fetch PC and issues one 2-beat AXI INCR read per pair.
//  Buffers both words and hands them to IF as one pair under valid/ready.
//  Removes the ad-hoc AR/R logic in the core top; handles redirects cleanly.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  fetch PC loaded by reset
//  AXI_ID    4'd0           constant arid value
// PORTS
//  clk          in   1   clock; all state on posedge
//  reset        in   1   asynchronous, active-high reset
//  fetch_en     in   1   allow new AR issue; when low, no new read starts
//  redirect     in   1   branch/jump/exception redirect strobe
//  redirect_pc  in   32  new fetch PC
//  out_valid    out  1   inst pair valid
//  out_ready    in   1   IF accepts the pair (low = stall)
//  out_inst_1   out  32  instruction at out_pc_1
//  out_inst_2   out  32  instruction at out_pc_2
//  out_pc_1     out  32  pair PC
//  out_pc_2     out  32  out_pc_1 + 4
//  out_err      out  1   1 = bad rresp or misaligned PC; both insts are 0
//  arid/araddr/arlen/arsize/arburst  out  4/32/4/3/2  AXI AR fields
//  arlock/arcache/arprot             out  2/4/3       driven 0
//  arvalid      out  1   AXI AR valid
//  arready      in   1   AXI AR ready
//  rdata/rresp/rlast/rvalid  in  32/2/1/1  AXI R channel
//  rready       out  1   AXI R ready
// BEHAVIOUR
//  Reset:
//   - pc = RESET_PC and state = IDLE.
//   - arvalid, rready, out_valid and out_err are 0.
//   - out_inst_* and araddr are 0.
//   - Constant fields: arlen = 4'd1, arsize = 3'b010, arburst = 2'b01, arid = AXI_ID.
//   - Reset mid-burst drops all state; the fabric is reset alongside.
//  States: IDLE, AR, R0, R1, HOLD, DRAIN.
//   IDLE:
//    - fetch_en=1 and pc[1:0]=0 -> AR; araddr is registered from pc.
//    - fetch_en=1 and pc[1:0]!=0 -> HOLD with out_err=1. No AXI read is issued.
//   AR:
//    - arvalid=1 and stays high until arready. It is never withdrawn, even on redirect.
//    - arready -> R0.
//   R0 / R1:
//    - rready=1.
//    - R0: beat 0 -> inst_1 buffer, then go to R1.
//    - R1: beat 1 (rlast) -> inst_2 buffer, then go to HOLD.
//    - out_err is the OR of (rresp != 2'b00) over both beats.
//   HOLD:
//    - out_valid=1 and the outputs are stable.
//    - On out_valid & out_ready: pc += 8 (32-bit wrap), then go to IDLE. Back-to-back AR issue is allowed from the next cycle.
//   DRAIN:
//    - rready=1; beats are discarded.
//    - The beat with rlast -> IDLE.
//  Latency: AR is issued 1 cycle after IDLE sees fetch_en. out_valid rises the cycle after the rlast beat.
//  Redirect (takes priority over the sequential pc update):
//   - pc <= redirect_pc in every state.
//   - IDLE or HOLD: go to IDLE and clear out_valid next cycle. A same-cycle HOLD handshake still counts as delivered.
//   - AR: finish the AR handshake, then go to DRAIN. A same-cycle arready also goes to DRAIN.
//   - R0 / R1: go to DRAIN. A same-cycle rlast beat goes straight to IDLE.
//   - A redirect while in DRAIN only updates pc.
//  rready is 0 outside R0, R1 and DRAIN. rid is ignored; there is one outstanding read only.
// STRUCTURE
//  Shared package (cpu_defs): RESET_PC, AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY, state encoding.
//  One natural sub-module: fetch_pair_buf. It is the 2-word plus PC/err holding register with a valid/ready output.
//  The FSM, pc register and AXI drive stay in this module.
// TESTING
//  Reset release, fetch_en=1, arready=1 -> araddr=BFC00000 and arlen=1. Beats 11111111/22222222 -> pair at pc BFC00000/BFC00004.
//  out_ready low for 5 cycles in HOLD -> outputs stay stable and arvalid stays 0. Next AR araddr = BFC00008.
//  Redirect to 80001000 while arvalid is high and arready is low:
//   - arvalid holds until arready, then 2 beats are drained.
//   - The next araddr is 80001000.
//   - No stale pair is ever valid.
//  Redirect with the rlast beat of an R1 burst -> IDLE, data dropped, next fetch at redirect_pc.
//  rresp=2'b10 on beat 0 -> out_valid with out_err=1. Redirect to 80000002 -> out_err pair with no AR issued.
//  pc=FFFFFFF8 pair accepted -> next araddr=00000000 (wrap).

Source files
------------

// File: rtl/inst_fetch_axi_pkg.sv
// Shared definitions for the instruction fetch AXI master.
package inst_fetch_axi_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [1:0]  AXI_BURST_INCR   = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B      = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
  localparam logic [3:0]  AXI_LEN_2BEAT    = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R0,
    S_R1,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_axi_pair_buf.sv
// Holding register for one fetched instruction pair plus its PC and error flag.
module fetch_pair_buf
  import inst_fetch_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        beat0_we_i,
  input  logic        beat1_we_i,
  input  logic        err_ld_i,
  input  logic        clr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  resp_i,
  output logic        valid_o,
  output logic [31:0] inst1_o,
  output logic [31:0] inst2_o,
  output logic [31:0] pc1_o,
  output logic [31:0] pc2_o,
  output logic        err_o
);

  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] inst1_q, inst1_d;
  logic [31:0] inst2_q, inst2_d;
  logic [31:0] pc_q, pc_d;

  // Next-state for the pair: beat writes, error-pair load and handshake clear.
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    inst1_d = inst1_q;
    inst2_d = inst2_q;
    pc_d    = pc_q;
    if (clr_i) valid_d = 1'b0;
    if (beat0_we_i) begin
      inst1_d = data_i;
      err_d   = (resp_i != AXI_RESP_OKAY);
    end
    if (beat1_we_i) begin
      inst2_d = data_i;
      err_d   = err_q | (resp_i != AXI_RESP_OKAY);
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
    if (err_ld_i) begin
      inst1_d = '0;
      inst2_d = '0;
      err_d   = 1'b1;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  // Pair storage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      inst1_q <= '0;
      inst2_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      inst1_q <= inst1_d;
      inst2_q <= inst2_d;
      pc_q    <= pc_d;
    end
  end

  // An errored pair never exposes bus data.
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign inst1_o = err_q ? '0 : inst1_q;
  assign inst2_o = err_q ? '0 : inst2_q;
  assign pc1_o   = pc_q;
  assign pc2_o   = pc_q + 32'd4;

endmodule

// File: rtl/inst_fetch_axi.sv
// Dual-issue instruction fetch master: one 2-beat AXI INCR read per pair.
module inst_fetch_axi
  import inst_fetch_axi_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [3:0]  AXI_ID   = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst_1,
  output logic [31:0] out_inst_2,
  output logic [31:0] out_pc_1,
  output logic [31:0] out_pc_2,
  output logic        out_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  araddr_q;
  logic         arvalid_q;
  logic         rready_q;
  logic         redir_pend_q;

  logic beat0_we, beat1_we, err_ld, clr;

  // Fetch sequencer: pc, AR/R handshakes and redirect handling.
  // A redirect during AR is remembered so the burst is drained once AR completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      redir_pend_q <= 1'b0;
    end else begin
      if (redirect) pc_q <= redirect_pc;
      case (state_q)
        S_IDLE: begin
          if (!redirect && fetch_en) begin
            if (pc_q[1:0] == 2'b00) begin
              state_q      <= S_AR;
              araddr_q     <= pc_q;
              arvalid_q    <= 1'b1;
              redir_pend_q <= 1'b0;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b1;
            redir_pend_q <= 1'b0;
            state_q      <= (redirect || redir_pend_q) ? S_DRAIN : S_R0;
          end else if (redirect) begin
            redir_pend_q <= 1'b1;
          end
        end
        S_R0: begin
          if (redirect) begin
            if (rvalid && rlast) begin
              rready_q <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (rvalid) begin
            state_q <= S_R1;
          end
        end
        S_R1: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            state_q  <= redirect ? S_IDLE : S_HOLD;
          end else if (redirect) begin
            state_q <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            state_q <= S_IDLE;
          end else if (out_ready) begin
            pc_q    <= pc_q + 32'd8;
            state_q <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (rvalid && rlast) begin
            rready_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pair buffer write strobes decoded from the sequencer state.
  always_comb begin
    beat0_we = (state_q == S_R0) && rvalid;
    beat1_we = (state_q == S_R1) && rvalid && !redirect;
    err_ld   = (state_q == S_IDLE) && !redirect && fetch_en && (pc_q[1:0] != 2'b00);
    clr      = (state_q == S_HOLD) && (redirect || out_ready);
  end

  fetch_pair_buf u_pair_buf (
    .clk        (clk),
    .rst        (reset),
    .beat0_we_i (beat0_we),
    .beat1_we_i (beat1_we),
    .err_ld_i   (err_ld),
    .clr_i      (clr),
    .pc_i       (pc_q),
    .data_i     (rdata),
    .resp_i     (rresp),
    .valid_o    (out_valid),
    .inst1_o    (out_inst_1),
    .inst2_o    (out_inst_2),
    .pc1_o      (out_pc_1),
    .pc2_o      (out_pc_2),
    .err_o      (out_err)
  );

  assign arid    = AXI_ID;
  assign araddr  = araddr_q;
  assign arlen   = AXI_LEN_2BEAT;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

endmodule
